// File: rtl/apb_req_arbiter_pkg.sv
// Shared types for the APB request arbiter: default-width bus types, FSM
// states and the latched request record.
package apbArb_package;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef logic [APB_ADDR_W-1:0] apbAddrSt;
  typedef logic [APB_DATA_W-1:0] apbDataSt;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } arbState_e;

  typedef struct packed {
    logic     write;
    apbAddrSt addr;
    apbDataSt wdata;
  } arbReq_t;

endpackage

// File: rtl/apb_req_arbiter_rr_grant.sv
// Combinational round-robin search: first set request at or above ptr, with
// wrap, yields a one-hot grant and its index.
module apb_rr_grant #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_grant && req[j]) begin
        any_grant = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB target among NUM_REQ request/response
// masters. Optional ACCESS-phase timeout under `APB_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | search for a requester, zero-wait accept, latch payload
// SETUP  | psel=1, penable=0
// ACCESS | psel=1, penable=1, wait for pready (or timeout)
// RESP   | one-cycle rsp_valid pulse to the granted requester
module apb_req_arbiter
  import apbArb_package::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         apb_paddr,
  output logic                      apb_psel,
  output logic                      apb_penable,
  output logic                      apb_pwrite,
  output logic [DATA_W-1:0]         apb_pwdata,
  input  logic                      apb_pready,
  input  logic [DATA_W-1:0]         apb_prdata,
  input  logic                      apb_pslverr
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("apb_req_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("apb_req_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  arbState_e          state, state_nxt;
  logic [IDX_W-1:0]   ptr, gnt_idx, sel_idx;
  logic [NUM_REQ-1:0] sel_onehot;
  logic               any_sel;
  logic               accept, capture, timeout_hit;
  logic               wr_q, err_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q, rdata_q;

  apb_rr_grant #(.NUM_REQ(NUM_REQ)) u_grant (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (sel_onehot),
    .grant_idx (sel_idx),
    .any_grant (any_sel)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] to_cnt;

  // Cleared in SETUP so every ACCESS phase starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           to_cnt <= '0;
    else if (state == SETUP)              to_cnt <= '0;
    else if (state == ACCESS && !apb_pready) to_cnt <= to_cnt + CNT_W'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    rsp_valid   = '0;
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (any_sel && rst_n) begin
          req_ready = sel_onehot;
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        apb_psel  = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        apb_psel    = 1'b1;
        apb_penable = 1'b1;
        if (apb_pready) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = RESP;
        end
`endif
      end
      RESP: begin
        rsp_valid = NUM_REQ'(1) << gnt_idx;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      gnt_idx <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        ptr     <= (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
        gnt_idx <= sel_idx;
        wr_q    <= req_write[sel_idx];
        addr_q  <= req_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
        wdata_q <= req_wdata[int'(sel_idx)*DATA_W +: DATA_W];
      end
      if (capture) begin
        rdata_q <= wr_q ? '0 : apb_prdata;
        err_q   <= apb_pslverr;
      end else if (timeout_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  // Payload registers hold from SETUP through the last ACCESS cycle.
  assign apb_paddr  = addr_q;
  assign apb_pwrite = wr_q;
  assign apb_pwdata = wdata_q;
  assign rsp_rdata  = (state == RESP) ? rdata_q : '0;
  assign rsp_err    = (state == RESP) ? err_q : 1'b0;

endmodule
